// File: rtl/instruction_prefetch_unit.sv
// Instruction fetch stage: issues sequential word reads, one outstanding at a time,
// queues returned instructions with their PCs and hands them to decode via valid/ready.
module instruction_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         bus_req,
    output logic [31:0]                  bus_addr,
    input  logic                         bus_gnt,
    input  logic                         bus_rvalid,
    input  logic [31:0]                  bus_rdata,
    output logic                         if_valid,
    output logic [31:0]                  if_instruction,
    output logic [31:0]                  if_pc,
    input  logic                         if_ready,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     last_instr_q, last_pc_q;

    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem    [DEPTH];

    logic            head_valid;
    logic            push;
    logic            pop;
    logic [31:0]     redirect_target;
    logic [CW-1:0]   post_push_count;
    logic            unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign head_valid = (count_q != '0);
    // A redirect flushes the queue, so any pop offered in the same cycle is void.
    assign pop = head_valid && if_ready && !redirect_valid;
    assign post_push_count = count_q + CW'(1) - CW'(pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        bus_req    = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                    state_d    = REQ;
                end else if (count_q < DEPTH_C) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    if (redirect_valid) begin
                        // The granted read now targets the old stream; its data is owed but stale.
                        fetch_pc_d = redirect_target;
                        state_d    = DISCARD;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        req_pc_d   = fetch_pc_q;
                        state_d    = WAIT;
                    end
                end else if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    if (redirect_valid) begin
                        fetch_pc_d = redirect_target;
                        state_d    = REQ;
                    end else begin
                        push    = 1'b1;
                        state_d = (post_push_count < DEPTH_C) ? REQ : IDLE;
                    end
                end else if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                    state_d    = DISCARD;
                end
            end
            DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_target;
                end
                if (bus_rvalid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= RESET_PC;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            // Shadow of the head so the outputs hold their last value once the queue drains.
            if (head_valid) begin
                last_instr_q <= instr_mem[rd_ptr_q];
                last_pc_q    <= pc_mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= bus_rdata;
            pc_mem[wr_ptr_q]    <= req_pc_q;
        end
    end

    assign bus_addr       = fetch_pc_q;
    assign if_valid       = head_valid;
    assign if_instruction = head_valid ? instr_mem[rd_ptr_q] : last_instr_q;
    assign if_pc          = head_valid ? pc_mem[rd_ptr_q]    : last_pc_q;
    assign queue_count    = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_C);
    a_push_has_space: assert property (@(posedge clk) disable iff (rst) push |-> (count_q < DEPTH_C));

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Directed bench for instruction_prefetch_unit: vector table for the free-run start-up,
// hand-written sequences for back-pressure, redirects and asynchronous reset.
module tb_instruction_prefetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned CW       = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          bus_req;
    logic [31:0]   bus_addr;
    logic          bus_gnt;
    logic          bus_rvalid;
    logic [31:0]   bus_rdata;
    logic          if_valid;
    logic [31:0]   if_instruction;
    logic [31:0]   if_pc;
    logic          if_ready;
    logic [CW-1:0] queue_count;

    instruction_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus_req        (bus_req),
        .bus_addr       (bus_addr),
        .bus_gnt        (bus_gnt),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .queue_count    (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic        gnt_en, resp_en, force_rvalid;
    logic        resp_pending;
    logic [31:0] resp_addr;
    logic [31:0] exp_pc;

    typedef struct {
        logic          rdy;
        logic          req;
        logic [31:0]   addr;
        logic          vld;
        logic [31:0]   pc;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hE300_0000 ^ a;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        total_cnt++;
        $display("FAIL %s: condition not reached within cycle budget", name);
    endtask

    // One clock cycle: bus model responds, scoreboard checks any pop, then advance to next negedge.
    task automatic step();
        logic [31:0] gaddr;
        logic        g;
        logic        rv;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        if (force_rvalid) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hDEAD_BEEF;
        end else if (resp_pending && resp_en) begin
            bus_rvalid = 1'b1;
            bus_rdata  = instr_of(resp_addr);
        end
        if (bus_req && gnt_en) bus_gnt = 1'b1;
        gaddr = bus_addr;
        g     = bus_gnt;
        rv    = bus_rvalid;
        if (if_valid && if_ready && !redirect_valid) begin
            $display("pop pc=%h instr=%h", if_pc, if_instruction);
            check32("pop_pc", if_pc, exp_pc);
            check32("pop_instr", if_instruction, instr_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        @(posedge clk);
        if (rv) resp_pending = 1'b0;
        if (g) begin
            resp_pending = 1'b1;
            resp_addr    = gaddr;
        end
        @(negedge clk);
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        resp_pending   = 1'b0;
        force_rvalid   = 1'b0;
        gnt_en         = 1'b1;
        resp_en        = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        bus_gnt        = 1'b0;
        bus_rvalid     = 1'b0;
        bus_rdata      = '0;
        exp_pc         = RESET_PC;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until_pop(input string name);
        logic [31:0] start;
        int n;
        start = exp_pc;
        n = 0;
        while (exp_pc == start && n < 30) begin
            step();
            n++;
        end
        if (exp_pc == start) timeout(name);
    endtask

    initial begin
        int  n;
        logic seen;

        vecs[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 3'd0};
        vecs[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 3'd0};
        vecs[2] = '{1'b1, 1'b0, 32'h04, 1'b0, 32'h0, 3'd0};
        vecs[3] = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h0, 3'd1};
        vecs[4] = '{1'b1, 1'b0, 32'h08, 1'b0, 32'h0, 3'd0};
        vecs[5] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h4, 3'd1};
        vecs[6] = '{1'b1, 1'b0, 32'h0C, 1'b0, 32'h0, 3'd0};
        vecs[7] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h8, 3'd1};

        // Reset state and zero-wait free run
        do_reset();
        check32("rst_if_pc", if_pc, 32'h0);
        check32("rst_if_instr", if_instruction, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if_ready = vecs[i].rdy;
            check32($sformatf("vec%0d_req", i), 32'(bus_req), 32'(vecs[i].req));
            check32($sformatf("vec%0d_addr", i), bus_addr, vecs[i].addr);
            check32($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vecs[i].vld));
            check32($sformatf("vec%0d_count", i), 32'(queue_count), 32'(vecs[i].cnt));
            if (vecs[i].vld) begin
                check32($sformatf("vec%0d_pc", i), if_pc, vecs[i].pc);
                check32($sformatf("vec%0d_instr", i), if_instruction, instr_of(vecs[i].pc));
            end
            step();
        end

        // Back-pressure: queue saturates, fetch idles, then drains in order
        do_reset();
        if_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check32("bp_count_bound", 32'(queue_count <= CW'(DEPTH)), 32'd1);
            step();
        end
        check32("bp_count_full", 32'(queue_count), 32'd4);
        check32("bp_req_idle", 32'(bus_req), 32'd0);
        check32("bp_fetch_pc", bus_addr, 32'h10);
        check32("bp_head_pc", if_pc, 32'h0);
        if_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (bus_req && !seen) begin
                check32("bp_resume_addr", bus_addr, 32'h10);
                seen = 1'b1;
            end
            step();
        end
        if (!seen) timeout("bp_resume_req");
        check32("bp_drain_progress", 32'(exp_pc > 32'h14), 32'd1);

        // Redirect while waiting on the response for 0x20
        do_reset();
        n = 0;
        while (!(bus_req && bus_addr == 32'h20) && n < 60) begin
            step();
            n++;
        end
        if (!(bus_req && bus_addr == 32'h20)) timeout("rw_reach_0x20");
        resp_en = 1'b0;
        step();
        check32("rw_in_wait_req", 32'(bus_req), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        step();
        redirect_valid = 1'b0;
        check32("rw_discard_req", 32'(bus_req), 32'd0);
        check32("rw_flush_count", 32'(queue_count), 32'd0);
        check32("rw_flush_valid", 32'(if_valid), 32'd0);
        resp_en = 1'b1;
        step();
        check32("rw_new_req", 32'(bus_req), 32'd1);
        check32("rw_new_addr", bus_addr, 32'h100);
        check32("rw_drop_count", 32'(queue_count), 32'd0);
        run_until_pop("rw_first_pop");

        // Redirect coincident with rvalid and a pop
        do_reset();
        if_ready = 1'b0;
        n = 0;
        while (!(!bus_req && resp_pending && queue_count >= CW'(1)) && n < 30) begin
            step();
            n++;
        end
        if (!(!bus_req && resp_pending && queue_count >= CW'(1))) timeout("rc_reach_wait");
        check32("rc_pre_valid", 32'(if_valid), 32'd1);
        if_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        check32("rc_count", 32'(queue_count), 32'd0);
        check32("rc_valid", 32'(if_valid), 32'd0);
        check32("rc_req", 32'(bus_req), 32'd1);
        check32("rc_addr", bus_addr, 32'h300);
        run_until_pop("rc_first_pop");

        // Redirect in REQ with no grant
        do_reset();
        gnt_en = 1'b0;
        n = 0;
        while (!bus_req && n < 10) begin
            step();
            n++;
        end
        if (!bus_req) timeout("rq_reach_req");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        check32("rq_req", 32'(bus_req), 32'd1);
        check32("rq_addr", bus_addr, 32'h200);
        step();
        check32("rq_hold_req", 32'(bus_req), 32'd1);
        check32("rq_hold_addr", bus_addr, 32'h200);
        gnt_en = 1'b1;
        run_until_pop("rq_first_pop");

        // Asynchronous reset mid-WAIT, then a late response in REQ
        do_reset();
        if_ready = 1'b0;
        n = 0;
        while (!(!bus_req && resp_pending && queue_count >= CW'(1)) && n < 30) begin
            step();
            n++;
        end
        if (!(!bus_req && resp_pending && queue_count >= CW'(1))) timeout("ar_reach_wait");
        resp_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check32("ar_req", 32'(bus_req), 32'd0);
        check32("ar_addr", bus_addr, RESET_PC);
        check32("ar_valid", 32'(if_valid), 32'd0);
        check32("ar_count", 32'(queue_count), 32'd0);
        check32("ar_pc", if_pc, 32'h0);
        check32("ar_instr", if_instruction, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        gnt_en   = 1'b0;
        if_ready = 1'b1;
        step();
        check32("ar_restart_req", 32'(bus_req), 32'd1);
        check32("ar_restart_addr", bus_addr, RESET_PC);
        resp_en = 1'b1;
        step();
        check32("ar_late_req", 32'(bus_req), 32'd1);
        check32("ar_late_count", 32'(queue_count), 32'd0);
        check32("ar_late_valid", 32'(if_valid), 32'd0);
        gnt_en = 1'b1;
        exp_pc = RESET_PC;
        run_until_pop("ar_first_pop");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch_unit.md
Name: instruction_prefetch_unit

Overview:
- Fetch stage that sits directly upstream of the decode/pipeline-register logic in arm_processor.
- Generates sequential word fetch addresses and issues them on a simple request/grant/response read bus, one request outstanding at a time.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding in-flight responses.

Parameters:
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- redirect_valid  input  1  branch taken in EX; flush and restart
- redirect_pc  input  32  new fetch address; bits [1:0] ignored and forced to 0
- bus_req  output  1  read request valid
- bus_addr  output  32  read request address
- bus_gnt  input  1  request accepted this cycle
- bus_rvalid  input  1  read data valid
- bus_rdata  input  32  read data
- if_valid  output  1  queue head valid
- if_instruction  output  32  queue head instruction
- if_pc  output  32  queue head PC
- if_ready  input  1  decode accepts head; low means stall
- queue_count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (asynchronous, immediate):
  - fetch_pc = RESET_PC; state = IDLE; queue empty; queue_count = 0.
  - bus_req = 0, bus_addr = RESET_PC.
  - if_valid = 0, if_instruction = 0, if_pc = 0.
- States:
  - IDLE: bus_req = 0. Go to REQ when queue_count < DEPTH.
  - REQ: bus_req = 1, bus_addr = fetch_pc. On bus_gnt: fetch_pc += 4 (mod 2^32), latch req_pc, go to WAIT.
  - WAIT: waiting for the response. On bus_rvalid: push {req_pc, bus_rdata}. Then go to REQ if post-push/post-pop count < DEPTH, else IDLE.
  - DISCARD: a response is owed but stale. On bus_rvalid: drop the data, go to REQ.
- Space reservation: a request is issued only while count < DEPTH. Because only one request is outstanding, a push can never overflow.
- Push/pop:
  - Pop when if_valid && if_ready.
  - Simultaneous push and pop is legal; count is unchanged.
  - A push becomes visible on if_valid the next cycle. Latency from bus_rvalid to if_valid is 1 cycle when the queue was empty.
- Head outputs come from the FIFO read pointer. if_valid = (count != 0). Pointers wrap modulo DEPTH.
- Redirect (redirect_valid = 1 at cycle N):
  - Queue flushed and fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Any pop at cycle N is ignored; if_valid = 0 at N+1.
  - IDLE/REQ with no bus_gnt: go to REQ. bus_req with the new address is asserted at N+1. Withdrawing or retargeting an ungranted request is legal on this bus.
  - REQ with bus_gnt at N: the granted request is stale; go to DISCARD.
  - WAIT with no bus_rvalid at N: go to DISCARD.
  - WAIT or DISCARD with bus_rvalid at N: drop the data, go to REQ.
  - DISCARD without bus_rvalid: stay in DISCARD; fetch_pc is updated to the latest redirect.
- bus_rvalid in IDLE or REQ is ignored (protocol error, no state change).
- if_instruction and if_pc hold their last value while if_valid = 0. Verification must not check them when invalid.
- A consumer stall (if_ready = 0) never blocks an in-flight response; space is already reserved.

Test Plan:
- Reset then free-run:
  - Stimulus: zero-wait bus (bus_gnt the same cycle as bus_req, bus_rvalid 1 cycle later), if_ready = 1.
  - Required: bus_addr = 0,4,8,…; if_pc follows 0,4,8 in order with matching if_instruction.
- Back-pressure:
  - Stimulus: if_ready = 0 for 20 cycles.
  - Required: queue_count saturates at 4, bus_req = 0 in IDLE, no drops.
  - Then if_ready = 1: entries PC 0,4,8,12 drain in order and fetch resumes at 16.
- Redirect during WAIT:
  - Stimulus: request to 0x20 granted; redirect_pc = 0x103 before the response arrives.
  - Required: the 0x20 data is discarded; next bus_addr = 0x100; first if_pc after the flush = 0x100.
- Redirect coincident with bus_rvalid and a pop:
  - Required: the pop is ignored, the returned data is dropped, and queue_count = 0 next cycle.
  - bus_req for the redirect target is asserted the next cycle.
- Redirect in REQ with no grant:
  - Stimulus: bus_gnt held low, redirect to 0x200.
  - Required: bus_addr changes to 0x200 the next cycle; no DISCARD.
- Asynchronous reset mid-WAIT:
  - Stimulus: rst asserted between clock edges.
  - Required: outputs clear immediately; after release, fetch restarts at RESET_PC; a late bus_rvalid arriving in REQ is ignored.
